multdiv_stall_ctrl: RTL and testbench
=====================================

Name: multdiv_stall_ctrl

Overview:
Sequences the shared multi-cycle multiplier/divider for execute-stage mul and div instructions. It latches operands, issues a one-cycle start pulse to the multdiv unit and stalls the front of the pipeline until a result or exception returns. It then emits a single writeback packet into the X/M latch. The packet targets $rd on success, or $rstatus ($r30) with the exception code on failure.

Parameters:
MAX_CYCLES, 40, wait cycles after start before a forced timeout.
RSTATUS_MUL, 4, value written to $r30 on a mul exception or mul timeout.
RSTATUS_DIV, 5, value written to $r30 on a div exception or div timeout.

Ports:
clock  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
ex_valid  in  1  execute-stage instruction is valid (not a bubble or flush).
ex_mul  in  1  decoded mul in execute.
ex_div  in  1  decoded div in execute.
ex_rd  in  5  destination register of the execute instruction.
ex_operandA  in  32  $rs value after bypassing.
ex_operandB  in  32  $rt value after bypassing.
md_ctrl_mult  out  1  start-multiply pulse.
md_ctrl_div  out  1  start-divide pulse.
md_operandA  out  32  latched operand A, held stable while busy.
md_operandB  out  32  latched operand B, held stable while busy.
md_result  in  32  multdiv result.
md_exception  in  1  overflow or divide-by-zero; valid with md_ready.
md_ready  in  1  result valid, one-cycle pulse.
stall  out  1  freeze PC, F/D and D/X latches.
busy  out  1  an operation is in flight.
wb_valid  out  1  writeback packet valid this cycle.
wb_reg  out  5  writeback register.
wb_data  out  32  writeback data.
timeout_err  out  1  sticky flag; set when a timeout occurs.

Behaviour:
- Reset (reset=0, async): state=IDLE and counter=0. Every output is 0, including md_operandA/B, wb_* and timeout_err. An in-flight operation is abandoned, and a later md_ready is ignored in IDLE.
- FSM states: IDLE, START, WAIT, DONE.
- IDLE:
  - trigger = ex_valid & (ex_mul | ex_div).
  - On trigger: latch operands, ex_rd and op (mul wins if both are set), then go to START.
  - stall is combinational and asserts in the trigger cycle itself.
  - Triggers are not recognised while ex_valid=0.
  - md_ready in IDLE is ignored.
- START:
  - Exactly one of md_ctrl_mult/md_ctrl_div is high, for this cycle only.
  - counter cleared; go to WAIT.
  - md_ready in START is ignored.
- WAIT:
  - counter increments each cycle.
  - On md_ready: register md_result and md_exception, go to DONE.
  - If counter reaches MAX_CYCLES-1 without md_ready: force exception, set timeout_err, go to DONE.
- DONE:
  - stall=0, so the mul/div leaves D/X.
  - On exception: wb_valid=1, wb_reg=30, wb_data=RSTATUS_MUL or RSTATUS_DIV per the latched op.
  - On success: wb_reg=latched rd, wb_data=latched result; wb_valid=1 unless rd==0, where wb_valid=0.
  - Next state is IDLE unconditionally.
- Outputs by state:
  - stall = trigger-in-IDLE | START | WAIT.
  - busy = START | WAIT | DONE.
  - wb_* are 0 outside DONE.
- Latency: with trigger at cycle T and md_ready at T+1+k (k≥1), wb_valid is high at T+2+k. stall is high for cycles T..T+1+k.
- md_operandA/B hold their latched value from START until the next trigger.
- Back-to-back ops: a new mul/div entering execute the cycle after DONE triggers normally from IDLE, with no extra gap.
- Counter width is clog2(MAX_CYCLES+1). The counter does not wrap.
- timeout_err clears only on reset.

Test Plan:
1. mul, A=7, B=6, rd=3, md_ready 3 cycles after the pulse -> a single md_ctrl_mult pulse; stall high for 5 cycles; then one cycle of wb_valid=1, wb_reg=3, wb_data=42; md_ctrl_div never asserts.
2. div, A=100, B=0, rd=8, md_ready with md_exception=1 -> wb_reg=30, wb_data=5, wb_valid=1; rd 8 is not written.
3. mul with overflow, md_exception=1 -> wb_reg=30, wb_data=4. Separately, a successful mul with rd=0 -> wb_valid stays 0.
4. div with md_ready never asserted -> DONE 40 cycles into WAIT; wb_reg=30, wb_data=5; timeout_err=1 and remains 1 afterwards.
5. mul (rd=2), then div (rd=4) entering execute right after DONE, with md_ready after 2 cycles each -> two separate pulses and two wb packets in order; no idle gap between ops. Also, ex_mul=1 with ex_valid=0 -> no pulse and no stall.
6. reset=0 asserted mid-WAIT -> all outputs 0 immediately; a late md_ready after reset release produces no wb_valid; a fresh div 9/3 then yields wb_data=3.

Source files
------------

// File: rtl/multdiv_stall_ctrl.sv
// Execute-stage sequencer for the shared multi-cycle mul/div unit: latches operands,
// pulses a start, stalls the front end until a result (or timeout) returns, then writes back.
module multdiv_stall_ctrl #(
    parameter int unsigned MAX_CYCLES  = 40,
    parameter int unsigned RSTATUS_MUL = 4,
    parameter int unsigned RSTATUS_DIV = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_mul,
    input  logic        ex_div,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_operandA,
    input  logic [31:0] ex_operandB,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic        stall,
    output logic        busy,
    output logic        wb_valid,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        timeout_err
);

    localparam int unsigned CntW = $clog2(MAX_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(MAX_CYCLES - 1);
    localparam logic [4:0] RstatusReg = 5'd30;

    typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            op_mul_q, op_mul_d;
    logic [4:0]      rd_q, rd_d;
    logic [31:0]     opa_q, opa_d;
    logic [31:0]     opb_q, opb_d;
    logic [31:0]     res_q, res_d;
    logic            exc_q, exc_d;
    logic            tout_q, tout_d;
    logic            trigger;

    assign trigger     = ex_valid & (ex_mul | ex_div);
    assign md_operandA = opa_q;
    assign md_operandB = opb_q;
    assign timeout_err = tout_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_mul_d     = op_mul_q;
        rd_d         = rd_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        res_d        = res_q;
        exc_d        = exc_q;
        tout_d       = tout_q;
        md_ctrl_mult = 1'b0;
        md_ctrl_div  = 1'b0;
        stall        = 1'b0;
        busy         = 1'b0;
        wb_valid     = 1'b0;
        wb_reg       = 5'd0;
        wb_data      = 32'd0;

        case (state_q)
            StIdle: begin
                if (trigger) begin
                    stall    = 1'b1;
                    op_mul_d = ex_mul;
                    rd_d     = ex_rd;
                    opa_d    = ex_operandA;
                    opb_d    = ex_operandB;
                    state_d  = StStart;
                end
            end
            StStart: begin
                stall        = 1'b1;
                busy         = 1'b1;
                md_ctrl_mult = op_mul_q;
                md_ctrl_div  = ~op_mul_q;
                cnt_d        = '0;
                state_d      = StWait;
            end
            StWait: begin
                stall = 1'b1;
                busy  = 1'b1;
                cnt_d = cnt_q + CntW'(1);
                if (md_ready) begin
                    res_d   = md_result;
                    exc_d   = md_exception;
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    // Unit never answered: report it as an exception of the latched op.
                    exc_d   = 1'b1;
                    tout_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                busy    = 1'b1;
                state_d = StIdle;
                if (exc_q) begin
                    wb_valid = 1'b1;
                    wb_reg   = RstatusReg;
                    wb_data  = op_mul_q ? 32'(RSTATUS_MUL) : 32'(RSTATUS_DIV);
                end else begin
                    wb_valid = (rd_q != 5'd0);
                    wb_reg   = rd_q;
                    wb_data  = res_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_mul_q <= 1'b0;
            rd_q     <= 5'd0;
            opa_q    <= 32'd0;
            opb_q    <= 32'd0;
            res_q    <= 32'd0;
            exc_q    <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_mul_q <= op_mul_d;
            rd_q     <= rd_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            res_q    <= res_d;
            exc_q    <= exc_d;
            tout_q   <= tout_d;
        end
    end

endmodule

// File: tb/tb_multdiv_stall_ctrl.sv
// Bench for multdiv_stall_ctrl: directed vector table, reset corner case, and randomized
// ops checked against a transaction-level model of the latency/writeback rules.
module tb_multdiv_stall_ctrl;

    localparam int MAXC = 40;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ex_valid = 1'b0, ex_mul = 1'b0, ex_div = 1'b0;
    logic [4:0]  ex_rd = 5'd0;
    logic [31:0] ex_operandA = 32'd0, ex_operandB = 32'd0;
    logic        md_ctrl_mult, md_ctrl_div;
    logic [31:0] md_operandA, md_operandB;
    logic [31:0] md_result = 32'd0;
    logic        md_exception = 1'b0, md_ready = 1'b0;
    logic        stall, busy, wb_valid, timeout_err;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;

    int checks = 0;
    int failures = 0;
    bit sticky_to = 1'b0;

    multdiv_stall_ctrl dut (
        .clock(clock), .reset(reset),
        .ex_valid(ex_valid), .ex_mul(ex_mul), .ex_div(ex_div), .ex_rd(ex_rd),
        .ex_operandA(ex_operandA), .ex_operandB(ex_operandB),
        .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
        .md_operandA(md_operandA), .md_operandB(md_operandB),
        .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
        .stall(stall), .busy(busy), .wb_valid(wb_valid), .wb_reg(wb_reg),
        .wb_data(wb_data), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          mul;
        bit          div;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        int          k;      // cycles from start pulse to md_ready
        bit          rdy;    // 0: md_ready never comes
        bit          exc;
        logic [31:0] res;
        bit          e_valid;
        logic [4:0]  e_reg;
        logic [31:0] e_data;
        int          e_stall;
    } vec_t;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk1({tag, " stall"}, stall, 1'b0);
        chk1({tag, " busy"}, busy, 1'b0);
        chk1({tag, " mult"}, md_ctrl_mult, 1'b0);
        chk1({tag, " div"}, md_ctrl_div, 1'b0);
        chk32({tag, " opA"}, md_operandA, 32'd0);
        chk32({tag, " opB"}, md_operandB, 32'd0);
        chk1({tag, " wb_valid"}, wb_valid, 1'b0);
        chk32({tag, " wb_reg"}, 32'(wb_reg), 32'd0);
        chk32({tag, " wb_data"}, wb_data, 32'd0);
        chk1({tag, " timeout_err"}, timeout_err, 1'b0);
    endtask

    // One non-triggering cycle in IDLE; md_ready here must be ignored.
    task automatic idle_cycle(input bit force_ready);
        @(negedge clock);
        ex_valid = 1'b0;
        ex_mul = 1'($urandom());
        ex_div = 1'($urandom());
        md_ready = force_ready ? 1'b1 : 1'($urandom());
        md_exception = 1'($urandom());
        md_result = $urandom();
        #1;
        chk1("idle stall", stall, 1'b0);
        chk1("idle busy", busy, 1'b0);
        chk1("idle mult", md_ctrl_mult, 1'b0);
        chk1("idle div", md_ctrl_div, 1'b0);
        chk1("idle wb_valid", wb_valid, 1'b0);
        chk1("idle timeout_err", timeout_err, sticky_to);
    endtask

    // Drives a whole op from the trigger cycle through DONE, checking per-cycle timing
    // derived from the latency rule; returns the observed writeback packet.
    task automatic run_op(input vec_t v, input bit noise, output bit o_valid,
                          output logic [4:0] o_reg, output logic [31:0] o_data,
                          output int o_stall);
        int wl;
        int last;
        wl = v.rdy ? v.k : MAXC;
        last = 2 + wl;
        o_stall = 0;
        o_valid = 1'b0;
        o_reg = 5'd0;
        o_data = 32'd0;
        for (int c = 0; c <= last; c++) begin
            @(negedge clock);
            if (c == 0) begin
                ex_valid = 1'b1; ex_mul = v.mul; ex_div = v.div; ex_rd = v.rd;
                ex_operandA = v.a; ex_operandB = v.b;
            end else if (c == last || !noise) begin
                ex_valid = 1'b0; ex_mul = 1'b0; ex_div = 1'b0;
            end else begin
                ex_valid = 1'($urandom()); ex_mul = 1'($urandom()); ex_div = 1'($urandom());
                ex_rd = 5'($urandom()); ex_operandA = $urandom(); ex_operandB = $urandom();
            end
            md_result = $urandom();
            md_exception = 1'($urandom());
            md_ready = 1'b0;
            if (v.rdy && c == 1 + wl) begin
                md_ready = 1'b1; md_result = v.res; md_exception = v.exc;
            end else if (noise && c <= 1) begin
                md_ready = 1'($urandom());
            end
            #1;
            if (stall) o_stall++;
            chk1($sformatf("stall c%0d", c), stall, c <= 1 + wl);
            chk1($sformatf("busy c%0d", c), busy, c >= 1);
            chk1($sformatf("mult pulse c%0d", c), md_ctrl_mult, c == 1 && v.mul);
            chk1($sformatf("div pulse c%0d", c), md_ctrl_div, c == 1 && !v.mul);
            if (c >= 1) begin
                chk32($sformatf("opA c%0d", c), md_operandA, v.a);
                chk32($sformatf("opB c%0d", c), md_operandB, v.b);
            end
            if (c < last) begin
                chk1($sformatf("wb_valid early c%0d", c), wb_valid, 1'b0);
                chk32($sformatf("wb_data early c%0d", c), wb_data, 32'd0);
                chk1($sformatf("timeout_err c%0d", c), timeout_err, sticky_to);
            end else begin
                o_valid = wb_valid;
                o_reg = wb_reg;
                o_data = wb_data;
                sticky_to = sticky_to | !v.rdy;
                chk1("timeout_err done", timeout_err, sticky_to);
            end
        end
    endtask

    vec_t tbl[8];

    initial begin
        bit          ov;
        logic [4:0]  oreg;
        logic [31:0] odata;
        int          ost;
        vec_t        v;
        bit          exc_eff;

        //            mul div a    b  rd  k  rdy exc res  e_v e_reg e_data e_stall
        tbl[0] = '{1, 0, 7,   6, 3,  3, 1, 0, 42, 1, 3,  42, 5};
        tbl[1] = '{0, 1, 100, 0, 8,  2, 1, 1, 0,  1, 30, 5,  4};
        tbl[2] = '{1, 0, 32'h8000_0000, 4, 11, 1, 1, 1, 0, 1, 30, 4, 3};
        tbl[3] = '{1, 0, 4,   5, 0,  2, 1, 0, 20, 0, 0,  20, 4};
        tbl[4] = '{1, 1, 3,   3, 9,  1, 1, 0, 9,  1, 9,  9,  3};
        tbl[5] = '{1, 0, 2,   8, 2,  2, 1, 0, 16, 1, 2,  16, 4};
        tbl[6] = '{0, 1, 20,  5, 4,  2, 1, 0, 4,  1, 4,  4,  4};
        tbl[7] = '{0, 1, 1,   1, 7,  0, 0, 0, 0,  1, 30, 5,  42};

        #1;
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_all_zero("post-reset");

        // Table rows run back to back with no idle cycle between them.
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i], 1'b0, ov, oreg, odata, ost);
            chk1($sformatf("tbl%0d wb_valid", i), ov, tbl[i].e_valid);
            chk32($sformatf("tbl%0d wb_reg", i), 32'(oreg), 32'(tbl[i].e_reg));
            chk32($sformatf("tbl%0d wb_data", i), odata, tbl[i].e_data);
            chk32($sformatf("tbl%0d stall cycles", i), ost, tbl[i].e_stall);
        end
        idle_cycle(1'b0);
        chk1("timeout_err sticky", timeout_err, 1'b1);

        // ex_mul without ex_valid must not start anything.
        @(negedge clock);
        ex_valid = 1'b0; ex_mul = 1'b1; ex_div = 1'b0; md_ready = 1'b0;
        #1;
        chk1("novalid stall", stall, 1'b0);
        @(negedge clock);
        #1;
        chk1("novalid pulse", md_ctrl_mult, 1'b0);
        chk1("novalid busy", busy, 1'b0);

        // Reset while waiting, then a stray md_ready, then a fresh div.
        @(negedge clock);
        ex_valid = 1'b1; ex_mul = 1'b1; ex_div = 1'b0; ex_rd = 5'd12;
        ex_operandA = 32'd11; ex_operandB = 32'd13;
        @(negedge clock);
        ex_valid = 1'b0; ex_mul = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #1;
        chk1("pre-reset busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        check_all_zero("async reset");
        sticky_to = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        idle_cycle(1'b1);
        idle_cycle(1'b0);
        v = '{0, 1, 9, 3, 5, 2, 1, 0, 3, 1, 5, 3, 4};
        run_op(v, 1'b0, ov, oreg, odata, ost);
        chk1("div9/3 wb_valid", ov, 1'b1);
        chk32("div9/3 wb_reg", 32'(oreg), 32'd5);
        chk32("div9/3 wb_data", odata, 32'd3);

        // Randomized ops against the writeback/latency rules.
        for (int n = 0; n < 30; n++) begin
            v.mul = 1'($urandom());
            v.div = v.mul ? 1'($urandom()) : 1'b1;
            v.a = $urandom();
            v.b = $urandom_range(0, 20);
            v.rd = 5'($urandom());
            v.k = $urandom_range(1, 45);
            v.rdy = (v.k <= MAXC);
            v.exc = ($urandom_range(0, 3) == 0);
            v.res = v.mul ? v.a * v.b : (v.b != 0 ? v.a / v.b : 32'd0);
            exc_eff = !v.rdy || v.exc;
            v.e_valid = exc_eff ? 1'b1 : (v.rd != 5'd0);
            v.e_reg = exc_eff ? 5'd30 : v.rd;
            v.e_data = exc_eff ? (v.mul ? 32'd4 : 32'd5) : v.res;
            v.e_stall = 2 + (v.rdy ? v.k : MAXC);
            run_op(v, 1'b1, ov, oreg, odata, ost);
            chk1($sformatf("rnd%0d wb_valid", n), ov, v.e_valid);
            chk32($sformatf("rnd%0d wb_reg", n), 32'(oreg), 32'(v.e_reg));
            chk32($sformatf("rnd%0d wb_data", n), odata, v.e_data);
            chk32($sformatf("rnd%0d stall cycles", n), ost, v.e_stall);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle_cycle(1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
